// File: rtl/piso_shift_tx_pkg.sv
// piso_shift_tx_pkg
// Shared definitions for the shift-register family (PISO transmitter and the
// planned SIPO receiver): FSM state encoding, bit-order constants and the
// frame-length helper.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   -> every frame carries one trailing even-parity bit
//   undefined -> frames carry data bits only
package piso_shift_tx_pkg;

  // Two-state framing FSM; encoding is shared with the receiver side.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-order selectors for the MSB_FIRST parameter of the family.
  localparam int ORDER_LSB_FIRST = 0;
  localparam int ORDER_MSB_FIRST = 1;

  // Number of serial bits in one frame for a given data width.
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter
// Frame position counter for the PISO transmitter. cnt holds the 1-based index
// of the bit currently on the serial line (0 when idle). terminal flags the
// final bit of the frame and is what releases the transmitter for the next word.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   start    in   a word is being accepted this cycle (next bit is bit 1)
//   active   in   transmitter is currently shifting a frame
//   cnt      out  current bit index, CNT_W bits
//   terminal out  current bit is the last bit of the frame
import piso_shift_tx_pkg::*;

module piso_bit_counter #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             active,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign terminal = active && (cnt_q == CNT_W'(N));
  assign cnt      = cnt_q;

  // A new word restarts at 1 even on the terminal cycle, which is what lets
  // back-to-back frames run with no gap.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(1);
    end else if (terminal) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and sends it one bit per clock, starting one cycle
// after the accept edge, with frame_start/frame_last markers for a SIPO
// receiver. A word offered on the final bit of a frame follows with no gap.
//
// Optional feature macro: PISO_PARITY_EN (appends one even-parity bit).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   load_valid   in   load_data holds a word to send
//   load_data    in   WIDTH-bit parallel word
//   load_ready   out  word can be accepted this cycle (combinational)
//   ser_out      out  serial data bit (registered, 0 when not valid)
//   ser_valid    out  ser_out carries a frame bit
//   frame_start  out  first bit of a frame
//   frame_last   out  final bit of a frame
//   busy         out  frame in flight (same as ser_valid)
import piso_shift_tx_pkg::*;

module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shift_reg_q;
  logic [WIDTH-1:0] shift_reg_d;
  logic             ser_out_q;
  logic             ser_out_d;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shift_rest;

`ifdef PISO_PARITY_EN
  logic parity_q;
  logic parity_d;
`endif

  piso_bit_counter #(
    .N     (FRAME_LEN),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .active   (state_q == ST_SHIFT),
    .cnt      (bit_cnt),
    .terminal (last_bit)
  );

  // Ready is gated by reset so nothing looks acceptable on a reset cycle.
  assign load_ready  = !reset && ((state_q == ST_IDLE) || last_bit);
  assign accept      = load_valid && load_ready;

  assign ser_out     = ser_out_q;
  assign ser_valid   = (state_q == ST_SHIFT);
  assign busy        = ser_valid;
  assign frame_start = (state_q == ST_SHIFT) && (bit_cnt == CNT_W'(1));
  assign frame_last  = last_bit;

  // The outgoing bit always comes from the "front" end of the register for the
  // chosen bit order; the register then shifts away from that end.
  always_comb begin
    if (MSB_FIRST == ORDER_MSB_FIRST) begin
      first_bit  = load_data[WIDTH-1];
      load_rest  = load_data << 1;
      next_bit   = shift_reg_q[WIDTH-1];
      shift_rest = shift_reg_q << 1;
    end else begin
      first_bit  = load_data[0];
      load_rest  = load_data >> 1;
      next_bit   = shift_reg_q[0];
      shift_rest = shift_reg_q >> 1;
    end
  end

  // Next-state and datapath. Accept is only possible in IDLE or on the final
  // bit, so it takes priority over the normal SHIFT progression.
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    ser_out_d   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      state_d     = ST_SHIFT;
      ser_out_d   = first_bit;
      shift_reg_d = load_rest;
`ifdef PISO_PARITY_EN
      parity_d    = ^load_data;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state_d     = ST_IDLE;
            shift_reg_d = '0;
          end else begin
            shift_reg_d = shift_rest;
`ifdef PISO_PARITY_EN
            // After the last data bit the parity captured at accept goes out.
            ser_out_d   = (bit_cnt == CNT_W'(WIDTH)) ? parity_q : next_bit;
`else
            ser_out_d   = next_bit;
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_reg_q <= '0;
      ser_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      ser_out_q   <= ser_out_d;
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx
// Directed bench for piso_shift_tx. Two instances (LSB-first and MSB-first)
// share the same stimulus. A frame-level model predicts every output each
// cycle; literal expected sequences pin the model's behaviour.
// Honours PISO_PARITY_EN when the bundle is built with it.
module tb_piso_shift_tx;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
  localparam logic [0:N-1]   SEQ_LSB = 5'b11011;
  localparam logic [0:N-1]   SEQ_MSB = 5'b10111;
  localparam logic [0:2*N-1] B2B_LSB = 10'b1101101100;
  localparam logic [0:2*N-1] B2B_MSB = 10'b1011101100;
`else
  localparam int N = WIDTH;
  localparam logic [0:N-1]   SEQ_LSB = 4'b1101;
  localparam logic [0:N-1]   SEQ_MSB = 4'b1011;
  localparam logic [0:2*N-1] B2B_LSB = 8'b11010110;
  localparam logic [0:2*N-1] B2B_MSB = 8'b10110110;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;

  logic l_ready, l_out, l_valid, l_start, l_last, l_busy;
  logic m_ready, m_out, m_valid, m_start, m_last, m_busy;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (l_ready),
    .ser_out     (l_out),
    .ser_valid   (l_valid),
    .frame_start (l_start),
    .frame_last  (l_last),
    .busy        (l_busy)
  );

  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (m_ready),
    .ser_out     (m_out),
    .ser_valid   (m_valid),
    .frame_start (m_start),
    .frame_last  (m_last),
    .busy        (m_busy)
  );

  // Frame-level model: the frame is a list of bits, pos is the 1-based index
  // of the bit currently expected on the line (0 = nothing in flight).
  int           pos = 0;
  logic [0:N-1] frm_lsb = '0;
  logic [0:N-1] frm_msb = '0;

  function automatic logic [0:N-1] build_frame(input logic [WIDTH-1:0] w, input bit msb);
    logic [0:N-1] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[i] = msb ? w[WIDTH-1-i] : w[i];
    end
`ifdef PISO_PARITY_EN
    f[WIDTH] = ^w;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pos <= 0;
    end else if (load_valid && (pos == 0 || pos == N)) begin
      frm_lsb <= build_frame(load_data, 1'b0);
      frm_msb <= build_frame(load_data, 1'b1);
      pos     <= 1;
    end else if (pos == N) begin
      pos <= 0;
    end else if (pos > 0) begin
      pos <= pos + 1;
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic ev, eready;
      ev     = (pos != 0);
      eready = !reset && (pos == 0 || pos == N);
      checkOutput("model lsb ser_valid",   l_valid, ev);
      checkOutput("model lsb busy",        l_busy,  ev);
      checkOutput("model lsb ser_out",     l_out,   ev ? frm_lsb[pos-1] : 1'b0);
      checkOutput("model lsb frame_start", l_start, pos == 1);
      checkOutput("model lsb frame_last",  l_last,  pos == N);
      checkOutput("model lsb load_ready",  l_ready, eready);
      checkOutput("model msb ser_valid",   m_valid, ev);
      checkOutput("model msb busy",        m_busy,  ev);
      checkOutput("model msb ser_out",     m_out,   ev ? frm_msb[pos-1] : 1'b0);
      checkOutput("model msb frame_start", m_start, pos == 1);
      checkOutput("model msb frame_last",  m_last,  pos == N);
      checkOutput("model msb load_ready",  m_ready, eready);
    end
  end

  // Drive inputs, let one rising edge happen, return just after it.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    load_valid = v;
    load_data  = d;
    reset      = r;
    @(posedge clk);
    #1;
  endtask

  // Literal check of one frame bit on both instances.
  task automatic checkBit(input string tag, input int k, input logic el, input logic em);
    checkOutput({tag, " lsb ser_out"},     l_out,   el);
    checkOutput({tag, " msb ser_out"},     m_out,   em);
    checkOutput({tag, " ser_valid"},       l_valid, 1'b1);
    checkOutput({tag, " frame_start"},     l_start, k == 0);
    checkOutput({tag, " frame_last"},      l_last,  k == N - 1);
    checkOutput({tag, " msb frame_last"},  m_last,  k == N - 1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ser_valid"},   l_valid, 1'b0);
    checkOutput({tag, " busy"},        l_busy,  1'b0);
    checkOutput({tag, " ser_out"},     l_out,   1'b0);
    checkOutput({tag, " frame_last"},  l_last,  1'b0);
    checkOutput({tag, " frame_start"}, l_start, 1'b0);
    checkOutput({tag, " msb ser_valid"}, m_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:N-1]   seq_l;
    logic [0:N-1]   seq_m;
    logic [0:2*N-1] b2b_l;
    logic [0:2*N-1] b2b_m;
    logic [WIDTH-1:0] words [4];
    seq_l = SEQ_LSB;
    seq_m = SEQ_MSB;
    b2b_l = B2B_LSB;
    b2b_m = B2B_MSB;
    words[0] = 4'h0;
    words[1] = 4'hA;
    words[2] = 4'h5;
    words[3] = 4'hF;

    // Reset held for two cycles, then released with no load.
    applyStimulus(1'b0, '0, 1'b1);
    check_en = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("reset load_ready", l_ready, 1'b0);
    checkIdle("reset");
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("after reset");
    checkOutput("after reset load_ready", l_ready, 1'b1);
    checkOutput("after reset msb load_ready", m_ready, 1'b1);

    // Single word 1011.
    applyStimulus(1'b1, 4'b1011, 1'b0);
    checkBit("single", 0, seq_l[0], seq_m[0]);
    for (int i = 1; i < N; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkBit("single", i, seq_l[i], seq_m[i]);
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("single end");

    // Back-to-back: 1011 then 0110 with load_valid held high.
    applyStimulus(1'b1, 4'b1011, 1'b0);
    checkBit("b2b", 0, b2b_l[0], b2b_m[0]);
    for (int i = 1; i < 2 * N; i++) begin
      applyStimulus((i <= N) ? 1'b1 : 1'b0, 4'b0110, 1'b0);
      checkBit("b2b", i % N, b2b_l[i], b2b_m[i]);
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("b2b end");

    // Load offered while not ready must be ignored.
    applyStimulus(1'b1, 4'b1011, 1'b0);
    checkBit("ignore", 0, seq_l[0], seq_m[0]);
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkBit("ignore", 1, seq_l[1], seq_m[1]);
    for (int i = 2; i < N; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkBit("ignore", i, seq_l[i], seq_m[i]);
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("ignore end");

    // Reset on bit 2 aborts the frame.
    applyStimulus(1'b1, 4'b1011, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkBit("abort", 1, seq_l[1], seq_m[1]);
    applyStimulus(1'b0, '0, 1'b1);
    checkIdle("abort");
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("abort release");
    checkOutput("abort load_ready", l_ready, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("abort quiet");

    // Reset dominates a pending load.
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkIdle("reset vs load");

    // Continuous streaming of several words; junk data between accepts.
    for (int w = 0; w < 4; w++) begin
      applyStimulus(1'b1, words[w], 1'b0);
      checkOutput("stream frame_start", l_start, 1'b1);
      for (int i = 1; i < N; i++) begin
        applyStimulus(1'b1, ~words[w], 1'b0);
      end
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkIdle("stream end");
    applyStimulus(1'b0, '0, 1'b0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
